vid_fill_engine: RTL and testbench
==================================

# vid_fill_engine

Hardware fill engine that sits upstream of the video controller's CPU bus port and writes a constant byte into a contiguous VRAM range without CPU involvement. It is programmed through a small byte-wide host register window. Once it wins the shared video-port arbiter, it issues ordinary write bus cycles (CE / DS / RnW / DSACK) to the video controller exactly as the CPU would. Typical uses are frame-buffer clear and rectangle-row fills on the back buffer.

## Interface
Parameters:
- TIMEOUT, 255, max cycles to wait for DSACK edge before abandoning a job (8-bit counter)

Ports:
- pixClk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- hostWr  in  1  one-cycle register write strobe
- hostAddr  in  3  register select
- hostWrData  in  8  register write data
- hostRdData  out  8  register read data, combinational on hostAddr
- fillReq  out  1  request for the video port
- fillGnt  in  1  arbiter grant
- nFillCE  out  1  video port chip enable, active low
- nFillDS  out  1  video port data strobe, active low
- fillRnW  out  1  read/write; constant 0 while granted, 1 otherwise
- fillAddr  out  16  video port address
- fillData  out  8  write data
- fillDataOe  out  1  data drive enable; high only in SETUP/STROBE
- nFillDSACK  in  1  video controller acknowledge, active low
- irq  out  1  level; high while DONE or ERR is set and IEN=1

## Operation
Register map (hostAddr):
- 0 ADDR_H, 1 ADDR_L: start address.
- 2 LEN_H, 3 LEN_L: byte count.
- 4 FILL: fill byte.
- 5 CTRL:
  - Write: bit0 START, bit1 ABORT, bit2 IEN, bit3 clear DONE/ERR.
  - Read: bit0 BUSY, bit1 DONE, bit2 ERR, bit3 IEN, bits 7:4 = 0.
- 6, 7: read 0, writes ignored.
- Reads of 0–3 return live working values.
- Writes to 0–4 are ignored while BUSY.

State machine:
- IDLE: START with LEN=0 sets DONE immediately; no request, no bus cycle. START with LEN≠0 sets BUSY and clears DONE/ERR → REQ. START while BUSY is ignored.
- REQ: fillReq=1. On fillGnt → SETUP.
- SETUP: drive fillAddr=ADDR, fillData=FILL, nFillCE=0, nFillDS=1. Next cycle → STROBE.
- STROBE: nFillDS=0. Wait for nFillDSACK=0 → RELEASE.
- RELEASE: nFillCE=1, nFillDS=1. Wait for nFillDSACK=1 → NEXT.
- NEXT:
  - ADDR+1 and LEN−1 (16-bit).
  - If LEN becomes 0 → DONE.
  - Else if ABORT is pending → DONE with ERR.
  - Else → SETUP.
  - CE is high for at least 2 cycles between writes (RELEASE + NEXT), which keeps the video controller from re-entering a write from a stale CE.
- DONE: fillReq=0, BUSY=0, DONE=1 → IDLE.

Boundary conditions:
- Address 0xFFFF is the video controller's control register and is never written. If NEXT would present 0xFFFF, the job ends with ERR=1, DONE=1, and LEN holds the unwritten remainder.
- A START with ADDR=0xFFFF errors the same way before any cycle is issued.
- ABORT is latched at any time. It takes effect in REQ (drop the request, no cycle issued) or in NEXT. A cycle in progress always completes.
- The timeout counter runs in STROBE and in RELEASE and resets on each state entry. Expiry ends the job with CE/DS high, ERR=1, DONE=1.
- fillGnt is sampled only in REQ. The arbiter holds the grant while fillReq=1.
- Reset mid-job: all strobes deassert on the next edge, no partial state is retained, and the engine returns to IDLE.

## Timing
- Reset values:
  - Strobes: nFillCE=1, nFillDS=1, nFillDSACK ignored.
  - Bus outputs: fillRnW=1, fillDataOe=0, fillReq=0, irq=0, fillAddr=0, fillData=0.
  - Registers: all 0.
- START edge → fillReq high on the next edge. Grant → CE low one edge later.
- Per byte: SETUP(1) + STROBE(≥1 + DSACK latency) + RELEASE(≥1) + NEXT(1). Against an idle controller in blanking, ≈7 cycles per byte.
- All outputs are registered. hostRdData is the only combinational output.
- DONE/irq assert the cycle after the final NEXT.

## Test plan
- Clear: ADDR=0x0000, LEN=0x0004, FILL=0xA5, START, grant immediately. Required: 4 writes to 0x0000–0x0003 with data 0xA5, CE high ≥2 cycles between them, DONE=1, LEN reads 0, fillReq low afterwards.
- Zero length: LEN=0, START. Required: DONE=1 the next cycle, CE never asserted.
- Register guard: ADDR=0xFFFD, LEN=5. Required: writes at 0xFFFD and 0xFFFE only, then ERR=1, DONE=1, LEN reads 3.
- Abort: LEN=100, ABORT during the 3rd STROBE. Required: the 3rd write completes, no 4th CE, ERR=1, LEN reads 97.
- Timeout: hold nFillDSACK=1. Required: after 255 STROBE cycles CE/DS return high, ERR=1, irq=1 (IEN set).
- Reset mid-job: assert reset in STROBE. Required: CE/DS/fillReq high/low at reset values on the next edge, CTRL reads 0.

Source files
------------

// File: rtl/vid_fill_engine.sv
// vid_fill_engine: writes a constant byte across a contiguous VRAM range
// through the video controller's CPU-style bus port (CE/DS/RnW/DSACK),
// programmed from a byte-wide host register window.
module vid_fill_engine #(
    parameter int TIMEOUT = 255
) (
    input  logic        pixClk,
    input  logic        reset,
    input  logic        hostWr,
    input  logic [2:0]  hostAddr,
    input  logic [7:0]  hostWrData,
    output logic [7:0]  hostRdData,
    output logic        fillReq,
    input  logic        fillGnt,
    output logic        nFillCE,
    output logic        nFillDS,
    output logic        fillRnW,
    output logic [15:0] fillAddr,
    output logic [7:0]  fillData,
    output logic        fillDataOe,
    input  logic        nFillDSACK,
    output logic        irq
);

    typedef enum logic [2:0] {
        stIdle, stReq, stSetup, stStrobe, stRelease, stNext, stDone
    } fillState_t;

    fillState_t  state;
    logic [15:0] addrReg, lenReg;
    logic [7:0]  fillReg, tmo;
    logic        busy, done, err, ien, abortPend;

    logic        ctrlWr, startAcc, lenZero, addrBad;
    logic [15:0] addrInc, lenDec;
    logic        waitingAck, tmoHit, reqAbort, nextEnd, nextErr, jobEnd;
    logic        setDone, setErr, doneNxt, errNxt, ienNxt;

    assign ctrlWr   = hostWr && (hostAddr == 3'd5);
    assign startAcc = ctrlWr && hostWrData[0] && !busy;
    assign lenZero  = (lenReg == 16'h0000);
    assign addrBad  = (addrReg == 16'hFFFF);
    assign addrInc  = addrReg + 16'd1;
    assign lenDec   = lenReg - 16'd1;

    // The timeout only counts while the controller has not yet moved DSACK.
    assign waitingAck = ((state == stStrobe) && nFillDSACK) ||
                        ((state == stRelease) && !nFillDSACK);
    assign tmoHit     = waitingAck && (tmo == 8'(TIMEOUT - 1));
    assign reqAbort   = (state == stReq) && abortPend;
    // 0xFFFF is the controller's own register, so it ends the job as an error.
    assign nextEnd    = (state == stNext) &&
                        ((lenDec == 16'h0000) || (addrInc == 16'hFFFF) || abortPend);
    assign nextErr    = (state == stNext) && (lenDec != 16'h0000) &&
                        ((addrInc == 16'hFFFF) || abortPend);
    assign jobEnd     = reqAbort || tmoHit || nextEnd;

    assign setDone = jobEnd || (startAcc && (lenZero || addrBad));
    assign setErr  = reqAbort || tmoHit || nextErr || (startAcc && !lenZero && addrBad);

    // Next status flags; computed here so irq can be registered in step with them.
    always_comb begin
        doneNxt = done;
        errNxt  = err;
        ienNxt  = ien;
        if (ctrlWr) ienNxt = hostWrData[2];
        if (startAcc || (ctrlWr && hostWrData[3])) begin
            doneNxt = 1'b0;
            errNxt  = 1'b0;
        end
        if (setDone) doneNxt = 1'b1;
        if (setErr)  errNxt  = 1'b1;
    end

    // Host read mux: live working values, status on CTRL.
    always_comb begin
        case (hostAddr)
            3'd0:    hostRdData = addrReg[15:8];
            3'd1:    hostRdData = addrReg[7:0];
            3'd2:    hostRdData = lenReg[15:8];
            3'd3:    hostRdData = lenReg[7:0];
            3'd4:    hostRdData = fillReg;
            3'd5:    hostRdData = {4'b0000, ien, err, done, busy};
            default: hostRdData = 8'h00;
        endcase
    end

    // ABORT is latched any time; a new START or the end of a job consumes it.
    always_ff @(posedge pixClk) begin
        if (reset)                            abortPend <= 1'b0;
        else if (startAcc)                    abortPend <= hostWrData[1];
        else if (ctrlWr && hostWrData[1])     abortPend <= 1'b1;
        else if (setDone)                     abortPend <= 1'b0;
    end

    // Register file, job sequencer and registered bus outputs.
    always_ff @(posedge pixClk) begin
        if (reset) begin
            state      <= stIdle;
            addrReg    <= '0;
            lenReg     <= '0;
            fillReg    <= '0;
            tmo        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ien        <= 1'b0;
            irq        <= 1'b0;
            fillReq    <= 1'b0;
            nFillCE    <= 1'b1;
            nFillDS    <= 1'b1;
            fillRnW    <= 1'b1;
            fillDataOe <= 1'b0;
            fillAddr   <= '0;
            fillData   <= '0;
        end else begin
            done <= doneNxt;
            err  <= errNxt;
            ien  <= ienNxt;
            irq  <= ienNxt && (doneNxt || errNxt);

            if (hostWr && !busy) begin
                case (hostAddr)
                    3'd0:    addrReg[15:8] <= hostWrData;
                    3'd1:    addrReg[7:0]  <= hostWrData;
                    3'd2:    lenReg[15:8]  <= hostWrData;
                    3'd3:    lenReg[7:0]   <= hostWrData;
                    3'd4:    fillReg       <= hostWrData;
                    default: ;
                endcase
            end

            case (state)
                stIdle, stDone: begin
                    state <= stIdle;
                    if (startAcc && !lenZero && !addrBad) begin
                        busy    <= 1'b1;
                        fillReq <= 1'b1;
                        state   <= stReq;
                    end
                end
                stReq: if (fillGnt) begin
                    state      <= stSetup;
                    nFillCE    <= 1'b0;
                    fillRnW    <= 1'b0;
                    fillDataOe <= 1'b1;
                    fillAddr   <= addrReg;
                    fillData   <= fillReg;
                end
                stSetup: begin
                    nFillDS <= 1'b0;
                    tmo     <= '0;
                    state   <= stStrobe;
                end
                stStrobe: if (!nFillDSACK) begin
                    nFillCE    <= 1'b1;
                    nFillDS    <= 1'b1;
                    fillDataOe <= 1'b0;
                    tmo        <= '0;
                    state      <= stRelease;
                end else begin
                    tmo <= tmo + 8'd1;
                end
                stRelease: if (nFillDSACK) state <= stNext;
                           else            tmo   <= tmo + 8'd1;
                stNext: begin
                    addrReg    <= addrInc;
                    lenReg     <= lenDec;
                    state      <= stSetup;
                    nFillCE    <= 1'b0;
                    fillDataOe <= 1'b1;
                    fillAddr   <= addrInc;
                    fillData   <= fillReg;
                end
                default: state <= stIdle;
            endcase

            // Any job termination overrides the branch above and parks the bus.
            if (jobEnd) begin
                state      <= stDone;
                busy       <= 1'b0;
                fillReq    <= 1'b0;
                nFillCE    <= 1'b1;
                nFillDS    <= 1'b1;
                fillRnW    <= 1'b1;
                fillDataOe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vid_fill_engine.sv
// Directed bench for vid_fill_engine: clear, zero length, register guard,
// abort, timeout and reset mid-job, with a simple DSACK responder.
module tb_vid_fill_engine;

    logic        pixClk, reset, hostWr;
    logic [2:0]  hostAddr;
    logic [7:0]  hostWrData, hostRdData;
    logic        fillReq, fillGnt, nFillCE, nFillDS, fillRnW;
    logic [15:0] fillAddr;
    logic [7:0]  fillData;
    logic        fillDataOe, nFillDSACK, irq;

    int checks = 0;
    int failures = 0;

    bit  ackEn;
    int  clrReq, clrSeen;
    int  wrCnt, ceFalls, minGap, ceRun;
    bit  seenLow, prevCE;
    logic [15:0] wrAddr [0:15];
    logic [7:0]  wrData [0:15];

    vid_fill_engine #(.TIMEOUT(255)) dut (
        .pixClk(pixClk), .reset(reset), .hostWr(hostWr), .hostAddr(hostAddr),
        .hostWrData(hostWrData), .hostRdData(hostRdData), .fillReq(fillReq),
        .fillGnt(fillGnt), .nFillCE(nFillCE), .nFillDS(nFillDS), .fillRnW(fillRnW),
        .fillAddr(fillAddr), .fillData(fillData), .fillDataOe(fillDataOe),
        .nFillDSACK(nFillDSACK), .irq(irq)
    );

    initial begin
        pixClk = 1'b0;
        forever #5 pixClk = ~pixClk;
    end

    // Idle video controller: acknowledges a strobe one cycle after it appears.
    initial begin
        nFillDSACK = 1'b1;
        forever begin
            @(posedge pixClk);
            #1;
            nFillDSACK = !(ackEn && !nFillCE && !nFillDS);
        end
    end

    // Bus monitor: logs completed writes and the shortest CE-high gap.
    initial begin
        clrSeen = 0; wrCnt = 0; ceFalls = 0; minGap = 99; ceRun = 0;
        seenLow = 0; prevCE = 1;
        forever begin
            @(negedge pixClk);
            if (clrReq != clrSeen) begin
                clrSeen = clrReq; wrCnt = 0; ceFalls = 0; minGap = 99;
                ceRun = 0; seenLow = 0; prevCE = 1;
            end
            if (!nFillCE && !nFillDS && !nFillDSACK && wrCnt < 16) begin
                wrAddr[wrCnt] = fillAddr;
                wrData[wrCnt] = fillData;
                wrCnt++;
            end
            if (nFillCE) ceRun++;
            else begin
                if (prevCE) begin
                    ceFalls++;
                    if (seenLow && ceRun < minGap) minGap = ceRun;
                end
                seenLow = 1;
                ceRun = 0;
            end
            prevCE = nFillCE;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pixClk);
        #1;
    endtask

    task automatic hw(input logic [2:0] a, input logic [7:0] d);
        hostAddr = a; hostWrData = d; hostWr = 1'b1;
        @(posedge pixClk);
        #1;
        hostWr = 1'b0;
    endtask

    task automatic chkRd(input string tag, input logic [2:0] a, input logic [7:0] exp);
        hostAddr = a;
        #1;
        chk(tag, 32'(hostRdData), 32'(exp));
    endtask

    task automatic setJob(input logic [15:0] a, input logic [15:0] l, input logic [7:0] f);
        hw(3'd0, a[15:8]); hw(3'd1, a[7:0]);
        hw(3'd2, l[15:8]); hw(3'd3, l[7:0]);
        hw(3'd4, f);
    endtask

    task automatic monClear();
        clrReq++;
        @(negedge pixClk);
        #1;
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (n < 300) begin
            @(posedge pixClk);
            #1;
            hostAddr = 3'd5;
            #1;
            if (hostRdData[1] === 1'b1) break;
            n++;
        end
        chk(tag, 32'(n < 300), 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1; hostWr = 1'b0; hostAddr = 3'd0; hostWrData = 8'h00;
        fillGnt = 1'b0; ackEn = 1'b1; clrReq = 0;

        // Reset state
        tick(3);
        chk("rst_ce", 32'(nFillCE), 32'd1);
        chk("rst_ds", 32'(nFillDS), 32'd1);
        chk("rst_rnw", 32'(fillRnW), 32'd1);
        chk("rst_oe", 32'(fillDataOe), 32'd0);
        chk("rst_req", 32'(fillReq), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_addr", 32'(fillAddr), 32'd0);
        chk("rst_data", 32'(fillData), 32'd0);
        chkRd("rst_ctrl", 3'd5, 8'h00);
        reset = 1'b0;
        tick(1);

        // Clear: 4 bytes of 0xA5 at 0x0000
        setJob(16'h0000, 16'h0004, 8'hA5);
        monClear();
        hw(3'd5, 8'h05);
        chk("clr_req", 32'(fillReq), 32'd1);
        chk("clr_ce_wait", 32'(nFillCE), 32'd1);
        fillGnt = 1'b1;
        tick(1);
        chk("clr_ce", 32'(nFillCE), 32'd0);
        chk("clr_ds_setup", 32'(nFillDS), 32'd1);
        chk("clr_rnw", 32'(fillRnW), 32'd0);
        chk("clr_oe", 32'(fillDataOe), 32'd1);
        chk("clr_addr0", 32'(fillAddr), 32'h0000);
        chk("clr_data0", 32'(fillData), 32'hA5);
        tick(1);
        chk("clr_ds_strobe", 32'(nFillDS), 32'd0);
        waitDone("clr_done_wait");
        chk("clr_wrcnt", 32'(wrCnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("clr_wr_addr", 32'(wrAddr[i]), 32'(i));
            chk("clr_wr_data", 32'(wrData[i]), 32'hA5);
        end
        chk("clr_gap", 32'(minGap >= 2), 32'd1);
        chkRd("clr_ctrl", 3'd5, 8'h0A);
        chkRd("clr_len_l", 3'd3, 8'h00);
        chkRd("clr_len_h", 3'd2, 8'h00);
        chkRd("clr_addr_l", 3'd1, 8'h04);
        chk("clr_req_off", 32'(fillReq), 32'd0);
        chk("clr_irq", 32'(irq), 32'd1);
        hw(3'd5, 8'h08);
        chkRd("clr_flags_cleared", 3'd5, 8'h00);
        chk("clr_irq_off", 32'(irq), 32'd0);

        // Zero length
        hw(3'd3, 8'h00);
        monClear();
        hw(3'd5, 8'h01);
        chkRd("zero_ctrl", 3'd5, 8'h02);
        tick(4);
        chk("zero_no_ce", 32'(ceFalls), 32'd0);
        chk("zero_no_req", 32'(fillReq), 32'd0);

        // Register guard: stops before 0xFFFF
        setJob(16'hFFFD, 16'h0005, 8'h5A);
        monClear();
        hw(3'd5, 8'h01);
        waitDone("guard_done_wait");
        chk("guard_wrcnt", 32'(wrCnt), 32'd2);
        chk("guard_wr0", 32'(wrAddr[0]), 32'hFFFD);
        chk("guard_wr1", 32'(wrAddr[1]), 32'hFFFE);
        chkRd("guard_ctrl", 3'd5, 8'h06);
        chkRd("guard_len_l", 3'd3, 8'h03);
        chkRd("guard_len_h", 3'd2, 8'h00);

        // START at 0xFFFF errors without a cycle
        setJob(16'hFFFF, 16'h0002, 8'h00);
        monClear();
        hw(3'd5, 8'h01);
        chkRd("ffff_ctrl", 3'd5, 8'h06);
        tick(3);
        chk("ffff_no_ce", 32'(ceFalls), 32'd0);
        chk("ffff_no_req", 32'(fillReq), 32'd0);

        // Abort during the 3rd strobe; host writes to FILL ignored while busy
        setJob(16'h0100, 16'd100, 8'hC3);
        monClear();
        hw(3'd5, 8'h01);
        n = 0;
        while (n < 200 && !(wrCnt == 2 && nFillDS == 1'b0)) begin
            tick(1);
            n++;
        end
        chk("abort_reach", 32'(n < 200), 32'd1);
        hw(3'd5, 8'h02);
        hw(3'd4, 8'hFF);
        waitDone("abort_done_wait");
        chk("abort_wrcnt", 32'(wrCnt), 32'd3);
        chk("abort_wr2", 32'(wrAddr[2]), 32'h0102);
        chk("abort_ce_count", 32'(ceFalls), 32'd3);
        chkRd("abort_ctrl", 3'd5, 8'h06);
        chkRd("abort_len_l", 3'd3, 8'h61);
        chkRd("abort_len_h", 3'd2, 8'h00);
        chkRd("abort_fill_kept", 3'd4, 8'hC3);

        // Timeout: controller never acknowledges
        ackEn = 1'b0;
        setJob(16'h0200, 16'h0001, 8'h11);
        monClear();
        hw(3'd5, 8'h05);
        tick(256);
        chk("tmo_still_strobe", 32'(nFillDS), 32'd0);
        tick(1);
        chk("tmo_ds", 32'(nFillDS), 32'd1);
        chk("tmo_ce", 32'(nFillCE), 32'd1);
        chk("tmo_irq", 32'(irq), 32'd1);
        chk("tmo_req", 32'(fillReq), 32'd0);
        chkRd("tmo_ctrl", 3'd5, 8'h0E);
        chkRd("tmo_len_l", 3'd3, 8'h01);

        // Reset mid-job while in STROBE
        setJob(16'h0300, 16'h0002, 8'h22);
        hw(3'd5, 8'h01);
        tick(3);
        chk("rmid_in_strobe", 32'(nFillDS), 32'd0);
        reset = 1'b1;
        tick(1);
        chk("rmid_ce", 32'(nFillCE), 32'd1);
        chk("rmid_ds", 32'(nFillDS), 32'd1);
        chk("rmid_req", 32'(fillReq), 32'd0);
        chk("rmid_rnw", 32'(fillRnW), 32'd1);
        chk("rmid_oe", 32'(fillDataOe), 32'd0);
        chk("rmid_addr", 32'(fillAddr), 32'd0);
        chk("rmid_irq", 32'(irq), 32'd0);
        chkRd("rmid_ctrl", 3'd5, 8'h00);
        chkRd("rmid_len_l", 3'd3, 8'h00);
        chkRd("rmid_addr_h", 3'd0, 8'h00);
        reset = 1'b0;
        ackEn = 1'b1;
        tick(1);

        // Single byte after recovery
        setJob(16'h0010, 16'h0001, 8'h3C);
        monClear();
        hw(3'd5, 8'h01);
        waitDone("post_done_wait");
        chk("post_wrcnt", 32'(wrCnt), 32'd1);
        chk("post_addr", 32'(wrAddr[0]), 32'h0010);
        chk("post_data", 32'(wrData[0]), 32'h3C);
        chkRd("post_ctrl", 3'd5, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
